// File: rtl/binary_coder_4_pkg.sv
// binary_coder_4_pkg: shared widths for the registered priority encoder.
package binary_coder_4_pkg;
    localparam int IN_W = 8;
    localparam int OUT_W = $clog2(IN_W);
    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/binary_coder_4_if.sv
// binary_coder_4_if: request vector in, encoded index and valid out.
interface binary_coder_4_if
    import binary_coder_4_pkg::*;
#(
    parameter int IN_W = binary_coder_4_pkg::IN_W,
    parameter int OUT_W = binary_coder_4_pkg::idx_w(IN_W)
);
    logic EN;
    logic [IN_W-1:0] In;
    logic [OUT_W-1:0] Y;
    logic Done;
    modport master (output EN, In, input Y, Done);
    modport slave (input EN, In, output Y, Done);
endinterface

// File: rtl/binary_coder_4_prio_enc_comb.sv
// prio_enc_comb: combinational highest-index priority encoder with an any flag.
module prio_enc_comb
    import binary_coder_4_pkg::*;
#(
    parameter int IN_W = binary_coder_4_pkg::IN_W,
    parameter int OUT_W = binary_coder_4_pkg::idx_w(IN_W)
) (
    input  logic [IN_W-1:0]  req,
    output logic [OUT_W-1:0] idx,
    output logic             any
);
    assign any = |req;
    // Ascending scan: the last hit, i.e. the highest set bit, wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < IN_W; i++)
            if (req[i]) idx = OUT_W'(i);
    end
endmodule

// File: rtl/binary_coder_4.sv
// binary_coder_4: registered IN_W-to-OUT_W priority encoder with enable and valid.
module binary_coder_4
    import binary_coder_4_pkg::*;
#(
    parameter int IN_W = binary_coder_4_pkg::IN_W,
    parameter int OUT_W = binary_coder_4_pkg::idx_w(IN_W)
) (
    input logic           clk,
    input logic           rst,
    binary_coder_4_if.slave bus
);
    logic [OUT_W-1:0] enc_idx, y_d, y_q;
    logic enc_any, done_d, done_q;
    prio_enc_comb #(.IN_W(IN_W), .OUT_W(OUT_W)) u_enc (
        .req(bus.In),
        .idx(enc_idx),
        .any(enc_any)
    );
    // Y is forced to zero whenever the result is not valid.
    always_comb begin
        done_d = bus.EN && enc_any;
        y_d = done_d ? enc_idx : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
            done_q <= 1'b0;
        end else begin
            y_q <= y_d;
            done_q <= done_d;
        end
    end
    assign bus.Y = y_q;
    assign bus.Done = done_q;
endmodule

// File: tb/tb_binary_coder_4.sv
// tb_binary_coder_4: directed and staggered-toggle checks of the registered encoder.
module tb_binary_coder_4;
    import binary_coder_4_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    binary_coder_4_if bus ();
    binary_coder_4 dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic drive(input logic r, input logic e, input logic [7:0] v);
        @(negedge clk);
        rst = r;
        bus.EN = e;
        bus.In = v;
        @(posedge clk);
        #1;
    endtask
    task automatic expect_out(input string tag, input logic [2:0] y, input logic d);
        chk({tag, ".y"}, 32'(bus.Y), 32'(y));
        chk({tag, ".done"}, 32'(bus.Done), 32'(d));
    endtask
    function automatic logic [3:0] ref_enc(input logic e, input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            if (v[i]) return e ? {1'b1, 3'(i)} : 4'd0;
        return 4'd0;
    endfunction
    logic [7:0] rin;
    logic ren;
    logic [3:0] exp_r;
    int per [9] = '{2, 3, 5, 7, 11, 13, 17, 19, 23};
    initial begin
        bus.EN = 1'b1;
        bus.In = 8'hFF;
        drive(1'b1, 1'b1, 8'hFF);
        expect_out("rst0", 3'd0, 1'b0);
        drive(1'b1, 1'b1, 8'hFF);
        expect_out("rst1", 3'd0, 1'b0);
        drive(1'b0, 1'b1, 8'hFF);
        expect_out("rst_rel", 3'd7, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 8'hA5);
            expect_out("dis", 3'd0, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, 8'(1 << k));
            expect_out($sformatf("walk%0d", k), 3'(k), 1'b1);
        end
        drive(1'b0, 1'b1, 8'b0010_1101);
        expect_out("prio_2d", 3'd5, 1'b1);
        drive(1'b0, 1'b1, 8'b0100_0011);
        expect_out("prio_43", 3'd6, 1'b1);
        drive(1'b0, 1'b1, 8'b0000_0110);
        expect_out("prio_06", 3'd2, 1'b1);
        drive(1'b0, 1'b1, 8'h00);
        expect_out("zero", 3'd0, 1'b0);
        drive(1'b0, 1'b1, 8'h80);
        expect_out("en_hi", 3'd7, 1'b1);
        drive(1'b0, 1'b0, 8'h80);
        expect_out("en_lo", 3'd0, 1'b0);
        drive(1'b0, 1'b1, 8'h10);
        expect_out("pre_rst", 3'd4, 1'b1);
        drive(1'b1, 1'b1, 8'hFF);
        expect_out("mid_rst", 3'd0, 1'b0);
        rin = 8'h00;
        ren = 1'b0;
        for (int c = 1; c <= 1000; c++) begin
            for (int b = 0; b < 8; b++)
                if (c % per[b] == 0) rin[b] = ~rin[b];
            if (c % per[8] == 0) ren = ~ren;
            exp_r = ref_enc(ren, rin);
            drive(1'b0, ren, rin);
            expect_out("rnd", exp_r[2:0], exp_r[3]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
